// File: rtl/obstacle_manager_pkg.sv
// Shared types and constants for the obstacle table and its renderer.
package obstacle_manager_pkg;

  localparam int NUM_OBSTACLES  = 10;
  localparam int SCREEN_WIDTH   = 1024;
  localparam int OBSTACLE_WIDTH = 32;
  localparam int LANE_HEIGHT    = 64;
  localparam int NUM_LANES      = 3;
  localparam int POS_W          = 11;
  localparam int SLOT_W         = $clog2(NUM_OBSTACLES);

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef struct packed {
    logic             active;
    logic [1:0]       lane;
    logic [POS_W-1:0] position;
  } obstacle_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SPAWN
  } state_t;

  // One step of the 16-bit Galois LFSR (right shift, feedback on bit 0).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // Only three lanes exist; the fourth LFSR code folds onto the middle lane.
  function automatic logic [1:0] lane_from_lfsr(input logic [15:0] v);
    return (v[1:0] == 2'd3) ? 2'd1 : v[1:0];
  endfunction

endpackage

// File: rtl/obstacle_manager_if.sv
// Control inputs and table outputs exchanged between the game controller and the obstacle manager.
interface obstacle_manager_if;
  import obstacle_manager_pkg::*;

  logic                           vsync_in;
  logic                           running_in;
  logic                           clear_in;
  logic [3:0]                     speed_in;
  obstacle_t [NUM_OBSTACLES-1:0]  obstacles;
  logic                           update_busy;
  logic [15:0]                    passed_count;
  logic                           spawn_dropped;

  modport master (
    output vsync_in, running_in, clear_in, speed_in,
    input  obstacles, update_busy, passed_count, spawn_dropped
  );

  modport slave (
    input  vsync_in, running_in, clear_in, speed_in,
    output obstacles, update_busy, passed_count, spawn_dropped
  );
endinterface

// File: rtl/obstacle_manager_lfsr16.sv
// 16-bit Galois LFSR that steps only when asked, so spawn randomness is frame-deterministic.
module lfsr16
  import obstacle_manager_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        advance,
  output logic [15:0] value
);

  // Step the shift register on request; hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) value <= SEED;
    else if (advance) value <= lfsr_step(value);
  end

endmodule

// File: rtl/obstacle_manager.sv
// Per-frame obstacle table update: scroll/retire in MOVE, one spawn attempt in SPAWN.
module obstacle_manager
  import obstacle_manager_pkg::*;
#(
  parameter int          SPAWN_MIN_FRAMES = 30,
  parameter int          SPAWN_RAND_BITS  = 6,
  parameter int          MIN_GAP          = 2 * OBSTACLE_WIDTH,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic              system_clock_in,
  input  logic              reset_n_in,
  obstacle_manager_if.slave bus
);

  localparam logic [POS_W-1:0]  GAP_LIMIT  = POS_W'(SCREEN_WIDTH - MIN_GAP);
  localparam logic [POS_W-1:0]  SPAWN_POS  = POS_W'(SCREEN_WIDTH - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_OBSTACLES - 1);
  localparam logic [15:0]       CNT_RESET  = 16'(SPAWN_MIN_FRAMES);

  state_t                        state_q, state_d;
  logic                          vsync_q;
  logic [SLOT_W-1:0]             idx_q;
  obstacle_t [NUM_OBSTACLES-1:0] table_q;
  logic [15:0]                   passed_q;
  logic                          dropped_q;
  logic [15:0]                   countdown_q;
  logic [NUM_LANES-1:0]          lane_blocked_q;
  logic                          free_found_q;
  logic [SLOT_W-1:0]             free_idx_q;
  logic [15:0]                   lfsr_value;

  // Frame tick is a falling edge of vsync; it starts an update only when idle and running.
  logic start;
  assign start = (state_q == ST_IDLE) && vsync_q && !bus.vsync_in && bus.running_in;

  // Slot currently walked by MOVE, with its post-move view.
  obstacle_t        cur;
  logic [POS_W-1:0] speed_ext, moved_pos;
  logic             retire, post_active;
  assign cur         = table_q[idx_q];
  assign speed_ext   = {{(POS_W-4){1'b0}}, bus.speed_in};
  assign retire      = cur.active && (cur.position < speed_ext);
  assign moved_pos   = cur.position - speed_ext;
  assign post_active = cur.active && !retire;

  // Spawn attempt uses the LFSR value after this attempt's single step.
  logic        attempt;
  logic [15:0] lfsr_adv, reload;
  logic [1:0]  spawn_lane;
  assign attempt    = (state_q == ST_SPAWN) && (countdown_q == 16'd0);
  assign lfsr_adv   = lfsr_step(lfsr_value);
  assign spawn_lane = lane_from_lfsr(lfsr_adv);
  assign reload     = CNT_RESET + 16'(lfsr_adv[SPAWN_RAND_BITS+1:2]);

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (system_clock_in),
    .reset_n (reset_n_in),
    .advance (attempt && !bus.clear_in),
    .value   (lfsr_value)
  );

  // State register.
  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; clear forces IDLE from anywhere.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_MOVE;
      ST_MOVE:  if (idx_q == LAST_SLOT) state_d = ST_SPAWN;
      ST_SPAWN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.clear_in) state_d = ST_IDLE;
  end

  // Table, counters and per-frame scratch (lane blocking, lowest free slot).
  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      // NOTE: the table is a handful of flops read by the renderer, so it is reset like any other state.
      table_q        <= '0;
      vsync_q        <= 1'b1;
      idx_q          <= '0;
      passed_q       <= '0;
      dropped_q      <= 1'b0;
      countdown_q    <= CNT_RESET;
      lane_blocked_q <= '0;
      free_found_q   <= 1'b0;
      free_idx_q     <= '0;
    end else begin
      vsync_q   <= bus.vsync_in;
      dropped_q <= 1'b0;
      if (bus.clear_in) begin
        table_q     <= '0;
        passed_q    <= '0;
        countdown_q <= CNT_RESET;
        idx_q       <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (start) begin
            idx_q          <= '0;
            lane_blocked_q <= '0;
            free_found_q   <= 1'b0;
            free_idx_q     <= '0;
          end
          ST_MOVE: begin
            if (retire) begin
              table_q[idx_q].active <= 1'b0;
              if (passed_q != 16'hFFFF) passed_q <= passed_q + 16'd1;
            end else if (cur.active) begin
              table_q[idx_q].position <= moved_pos;
            end
            if (post_active && (moved_pos > GAP_LIMIT)) lane_blocked_q[cur.lane] <= 1'b1;
            if (!post_active && !free_found_q) begin
              free_found_q <= 1'b1;
              free_idx_q   <= idx_q;
            end
            idx_q <= idx_q + SLOT_W'(1);
          end
          ST_SPAWN: begin
            if (!attempt) begin
              countdown_q <= countdown_q - 16'd1;
            end else if (lane_blocked_q[spawn_lane]) begin
              countdown_q <= 16'd1;
            end else if (!free_found_q) begin
              dropped_q   <= 1'b1;
              countdown_q <= reload;
            end else begin
              table_q[free_idx_q] <= obstacle_t'{active: 1'b1, lane: spawn_lane, position: SPAWN_POS};
              countdown_q         <= reload;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.obstacles     = table_q;
  assign bus.update_busy   = (state_q != ST_IDLE);
  assign bus.passed_count  = passed_q;
  assign bus.spawn_dropped = dropped_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// Randomized frame-level bench for obstacle_manager against a frame-at-a-time reference model.
module tb_obstacle_manager;
  import obstacle_manager_pkg::*;

  localparam int          MIN_FRAMES = 1;
  localparam int          RAND_BITS  = 2;
  localparam int          GAP        = 2 * OBSTACLE_WIDTH;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          BUSY_LEN   = NUM_OBSTACLES + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obstacle_manager_if bus ();

  obstacle_manager #(
    .SPAWN_MIN_FRAMES (MIN_FRAMES),
    .SPAWN_RAND_BITS  (RAND_BITS),
    .MIN_GAP          (GAP),
    .LFSR_SEED        (SEED)
  ) dut (
    .system_clock_in (clk),
    .reset_n_in      (rst_n),
    .bus             (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: whole-frame view of the table.
  bit          m_active [NUM_OBSTACLES];
  int          m_lane   [NUM_OBSTACLES];
  int          m_pos    [NUM_OBSTACLES];
  int          m_passed;
  int          m_countdown;
  logic [15:0] m_lfsr;
  int          drops_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      m_active[i] = 1'b0;
      m_lane[i]   = 0;
      m_pos[i]    = 0;
    end
    m_passed    = 0;
    m_countdown = MIN_FRAMES;
  endtask

  task automatic model_reset();
    model_clear();
    m_lfsr = SEED;
  endtask

  // One accepted frame: scroll/retire everything, then at most one spawn attempt.
  task automatic model_frame(input int spd, output bit drop);
    bit blocked [3];
    int free_slot;
    int lane;
    int reload;
    drop = 1'b0;
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      if (m_active[i]) begin
        if (m_pos[i] < spd) begin
          m_active[i] = 1'b0;
          if (m_passed < 65535) m_passed++;
        end else begin
          m_pos[i] -= spd;
        end
      end
    end
    for (int l = 0; l < 3; l++) blocked[l] = 1'b0;
    for (int i = 0; i < NUM_OBSTACLES; i++)
      if (m_active[i] && m_pos[i] > SCREEN_WIDTH - GAP) blocked[m_lane[i]] = 1'b1;
    free_slot = -1;
    for (int i = 0; i < NUM_OBSTACLES; i++)
      if (!m_active[i] && free_slot < 0) free_slot = i;
    if (m_countdown > 0) begin
      m_countdown--;
    end else begin
      m_lfsr = ref_lfsr(m_lfsr);
      lane   = int'(m_lfsr[1:0]);
      if (lane == 3) lane = 1;
      reload = MIN_FRAMES + int'(m_lfsr[15:2]) % (1 << RAND_BITS);
      if (blocked[lane]) begin
        m_countdown = 1;
      end else if (free_slot < 0) begin
        drop        = 1'b1;
        m_countdown = reload;
      end else begin
        m_active[free_slot] = 1'b1;
        m_lane[free_slot]   = lane;
        m_pos[free_slot]    = SCREEN_WIDTH - 1;
        m_countdown         = reload;
      end
    end
  endtask

  task automatic check_table(input string tag);
    logic [13:0] exp;
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      exp = {m_active[i], 2'(m_lane[i]), 11'(m_pos[i])};
      check($sformatf("%s slot%0d", tag, i), {18'd0, bus.obstacles[i]}, {18'd0, exp});
    end
    check($sformatf("%s passed_count", tag), {16'd0, bus.passed_count}, 32'(m_passed));
  endtask

  // Drive one vsync falling edge and watch the whole update window.
  task automatic frame(input int spd, input int stop_at);
    bit accepted;
    bit exp_drop;
    int busy_n;
    int drop_n;
    @(negedge clk);
    accepted     = bus.running_in;
    bus.speed_in = 4'(spd);
    bus.vsync_in = 1'b0;
    busy_n = 0;
    drop_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == stop_at) bus.running_in = 1'b0;
      if (bus.update_busy) busy_n++;
      if (bus.spawn_dropped) drop_n++;
    end
    bus.vsync_in = 1'b1;
    exp_drop = 1'b0;
    if (accepted) model_frame(spd, exp_drop);
    if (exp_drop) drops_seen++;
    check("busy_cycles", 32'(busy_n), accepted ? 32'(BUSY_LEN) : 32'd0);
    check("drop_pulses", 32'(drop_n), 32'(exp_drop));
    check_table("frame");
  endtask

  initial begin
    drops_seen     = 0;
    bus.vsync_in   = 1'b1;
    bus.running_in = 1'b0;
    bus.clear_in   = 1'b0;
    bus.speed_in   = 4'd0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", 32'(bus.update_busy), 32'd0);
    check("reset dropped", 32'(bus.spawn_dropped), 32'd0);
    check_table("reset");

    // First tick only counts down; second tick spawns into slot 0 at the right edge.
    bus.running_in = 1'b1;
    frame(0, -1);
    frame(0, -1);
    check("spawn slot0 active", 32'(bus.obstacles[0].active), 32'd1);
    check("spawn slot0 position", 32'(bus.obstacles[0].position), 32'(SCREEN_WIDTH - 1));

    // Random scrolling: fills the table, retires off the left edge, exercises blocking and drops.
    for (int f = 0; f < 300; f++) frame($urandom_range(0, 15), -1);

    // Ticks while not running are discarded.
    bus.running_in = 1'b0;
    repeat (3) frame($urandom_range(1, 15), -1);
    bus.running_in = 1'b1;

    // running_in falls mid-update: this update finishes, the next tick is ignored.
    frame(9, 4);
    frame(9, -1);
    bus.running_in = 1'b1;
    frame(9, -1);

    // Asynchronous reset in the middle of MOVE.
    @(negedge clk);
    bus.speed_in = 4'd5;
    bus.vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async reset busy", 32'(bus.update_busy), 32'd0);
    check_table("async reset");
    @(negedge clk);
    bus.vsync_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 40; f++) frame($urandom_range(0, 15), -1);

    // clear_in while MOVE is on slot 4: empty table and IDLE on the next cycle, LFSR kept.
    @(negedge clk);
    bus.speed_in = 4'd3;
    bus.vsync_in = 1'b0;
    repeat (5) @(negedge clk);
    check("busy before clear", 32'(bus.update_busy), 32'd1);
    bus.clear_in = 1'b1;
    @(negedge clk);
    bus.clear_in = 1'b0;
    model_clear();
    check("clear busy", 32'(bus.update_busy), 32'd0);
    check_table("clear");
    repeat (3) @(negedge clk);
    check("clear stays idle", 32'(bus.update_busy), 32'd0);
    bus.vsync_in = 1'b1;

    // Slow scrolling keeps fresh spawns near the edge, so blocked lanes retry frame after frame.
    for (int f = 0; f < 60; f++) frame($urandom_range(0, 2), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
